// File: rtl/writeback_queue_if.sv
// Bundle of the writeback queue's producer, register-file write and forwarding signals.
// The slave modport is the queue; the master modport is whoever drives the pipeline side.
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              wb_hold;
    logic              regwrite;
    logic [ADDR_W-1:0] adr_wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] adr_reg1;
    logic [ADDR_W-1:0] adr_reg2;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_addr, in_data, wb_hold, adr_reg1, adr_reg2,
        output in_ready, regwrite, adr_wr_reg, wr_data,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );

    modport master (
        output in_valid, in_addr, in_data, wb_hold, adr_reg1, adr_reg2,
        input  in_ready, regwrite, adr_wr_reg, wr_data,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );
endinterface

// File: rtl/writeback_queue.sv
// Small FIFO between execute/load results and the register-file write port,
// draining one write per cycle and forwarding pending values to both read ports.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    writeback_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic empty, full, push, enq, pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
        push  = bus.in_valid & ~full;
        // Writes to x0 finish the handshake but never occupy an entry.
        enq   = push & (bus.in_addr != '0);
        pop   = ~empty & ~bus.wb_hold;

        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            addr_d[wr_ptr_q]  = bus.in_addr;
            data_d[wr_ptr_q]  = bus.in_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        bus.in_ready   = ~full;
        bus.regwrite   = pop;
        bus.adr_wr_reg = empty ? '0 : addr_q[rd_ptr_q];
        bus.wr_data    = empty ? '0 : data_q[rd_ptr_q];
        bus.count      = count_q;
    end

    // Scan oldest to youngest so the last match seen is the youngest pending value.
    logic [PTR_W-1:0] idx;
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data2 = '0;
        idx           = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[idx] && (bus.adr_reg1 != '0) && (addr_q[idx] == bus.adr_reg1)) begin
                bus.fwd_hit1  = 1'b1;
                bus.fwd_data1 = data_q[idx];
            end
            if (valid_q[idx] && (bus.adr_reg2 != '0) && (addr_q[idx] == bus.adr_reg2)) begin
                bus.fwd_hit2  = 1'b1;
                bus.fwd_data2 = data_q[idx];
            end
        end
    end
endmodule
